ir_nec_transmit: RTL
====================

Name: ir_nec_transmit

Overview:
- NEC-protocol infrared transmitter; the transmit-side counterpart of the IR receive path.
- Accepts a 32-bit code word through a ready/start handshake and serialises it LSB first.
- Frame: 9 ms leader mark, 4.5 ms space, 32 pulse-distance bits, stop mark. Also emits NEC repeat frames.
- Drives the IrDA/IR LED pin with a 38 kHz modulated mark. Bit order matches the receiver's 32-bit word, so [31:16] = {~key, key}, e.g. 16'hfe01 for button 1.

Parameters:
- UNIT_CYCLES, 28125, clock cycles per 562.5 µs NEC unit at 50 MHz.
- CARRIER_DIV, 1316, carrier period in cycles (50 MHz / 38 kHz).
- CARRIER_HIGH, 439, carrier high cycles per period (≈1/3 duty).
- GAP_UNITS, 72, idle units enforced after every frame before tx_ready reasserts.
- CARRIER_EN, 1, 1 = modulate marks; 0 = irda_txd outputs the raw envelope.

Ports:
- clk  input  1  system clock (50 MHz)
- reset  input  1  asynchronous active-low reset
- tx_start  input  1  request a data frame; accepted when tx_ready=1
- tx_repeat  input  1  request a repeat frame; accepted when tx_ready=1
- tx_data  input  32  code word; bit 0 transmitted first; captured on accept
- tx_ready  output  1  idle and able to accept
- tx_done  output  1  one-cycle pulse when a frame, including its gap, completes
- tx_envelope  output  1  unmodulated mark (1) / space (0)
- irda_txd  output  1  LED drive, active high

Behaviour:
- Reset: asynchronous, active-low; all state is cleared immediately regardless of clk.
  - Reset values: tx_ready=1, tx_done=0, tx_envelope=0, irda_txd=0, FSM=IDLE, all counters 0.
  - Reset mid-frame aborts the frame; the LED turns off in the same instant; no tx_done is issued.
- Accept: tx_start or tx_repeat high on a rising edge with tx_ready=1.
  - tx_start has priority if both are high.
  - tx_data is latched into the shift register on accept.
  - tx_ready=0 from the next cycle.
  - Requests while tx_ready=0 are ignored, not queued.
- Latency: tx_envelope=1 in the cycle after accept.
- Every segment lasts exactly N*UNIT_CYCLES cycles, counted by a unit-cycle counter plus a unit counter.
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, REP_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
  - IDLE -> LEAD_MARK on accept.
  - LEAD_MARK: 16 units mark. Exits to LEAD_SPACE for a data frame, REP_SPACE for a repeat frame.
  - LEAD_SPACE: 8 units space, then BIT_MARK with bit index 0.
  - REP_SPACE: 4 units space, then STOP_MARK.
  - BIT_MARK: 1 unit mark, then BIT_SPACE.
  - BIT_SPACE: 3 units if the current bit is 1, 1 unit if it is 0.
    - Then shift right and increment the index.
    - After index 31 -> STOP_MARK; otherwise -> BIT_MARK.
  - STOP_MARK: 1 unit mark, then GAP.
  - GAP: GAP_UNITS units space. On its last cycle, pulse tx_done; the next cycle is IDLE with tx_ready=1.
- tx_envelope: 1 in LEAD_MARK, BIT_MARK and STOP_MARK; 0 otherwise.
- Carrier:
  - The carrier counter restarts at 0 on the first cycle of every mark, so each mark begins high.
  - Carrier output = (cnt < CARRIER_HIGH); the counter wraps at CARRIER_DIV-1.
  - irda_txd = tx_envelope & carrier, or tx_envelope when CARRIER_EN=0.
  - irda_txd=0 in every space regardless of carrier phase.
- Timing arithmetic:
  - Counter widths are derived with $clog2 of the parameters.
  - Data frame mark+space = (24 + 64 + 2·popcount(tx_data) + 1) units; the gap follows.
  - Repeat frame mark+space = 21 units; the gap follows.
- tx_data changes after accept have no effect on the frame in flight.

Decomposition:
- Package ir_nec_pkg holds:
  - the state enum type;
  - unit-count constants: LEAD_MARK_UNITS=16, LEAD_SPACE_UNITS=8, REP_SPACE_UNITS=4, BIT_MARK_UNITS=1, ONE_SPACE_UNITS=3, ZERO_SPACE_UNITS=1, STOP_MARK_UNITS=1, FRAME_BITS=32.
- One sub-module: ir_carrier_gen.
  - Inputs: clk, reset, restart, enable.
  - Output: the carrier.
  - Parameterised by CARRIER_DIV and CARRIER_HIGH.

Test Plan (UNIT_CYCLES=4, CARRIER_DIV=3, CARRIER_HIGH=1, GAP_UNITS=8 unless stated):
- Reset release with no request -> tx_ready=1, irda_txd=0 and tx_envelope=0 held for 100 cycles.
- Data frame:
  - Stimulus: tx_start with tx_data=32'hfe01_00ff.
  - Envelope: 64-cycle mark, then 32-cycle space.
  - Bits: bits 0–7 give a 4-cycle mark and a 12-cycle space; bits 8–15 give a 4-cycle mark and a 4-cycle space.
  - Ends with a 4-cycle stop mark: 484 cycles total, then a 32-cycle gap.
  - tx_done pulses once; tx_ready is back 517 cycles after accept.
  - Decoding the envelope against the NEC timings yields 32'hfe01_00ff.
- Repeat frame:
  - Stimulus: tx_repeat.
  - Envelope: 64 mark, 16 space, 4 mark, 32 gap.
  - tx_done fires once, 116 cycles after accept.
  - No data bits appear.
- Priority and busy:
  - tx_start and tx_repeat together -> data frame is sent.
  - tx_start pulsed mid-frame -> ignored; exactly one tx_done.
  - Changing tx_data mid-frame does not alter the emitted bits.
- Carrier, CARRIER_EN=1:
  - During every mark, irda_txd follows the pattern 1,0,0 repeating, starting high on the first mark cycle.
  - irda_txd=0 throughout every space.
  - With CARRIER_EN=0, irda_txd == tx_envelope.
- Reset asserted 200 cycles into a data frame:
  - irda_txd and tx_envelope go to 0 asynchronously; tx_ready=1; no tx_done.
  - A new tx_start after release produces a complete, correct frame.

Source files
------------

// File: rtl/ir_nec_transmit_pkg.sv
// Shared types and NEC segment lengths for the IR transmit path.
// Segment lengths are expressed in 562.5 us NEC units.
package ir_nec_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LEAD_MARK  = 3'd1,
      LEAD_SPACE = 3'd2,
      REP_SPACE  = 3'd3,
      BIT_MARK   = 3'd4,
      BIT_SPACE  = 3'd5,
      STOP_MARK  = 3'd6,
      GAP        = 3'd7
   } state_t;

   localparam int LEAD_MARK_UNITS  = 16;
   localparam int LEAD_SPACE_UNITS = 8;
   localparam int REP_SPACE_UNITS  = 4;
   localparam int BIT_MARK_UNITS   = 1;
   localparam int ONE_SPACE_UNITS  = 3;
   localparam int ZERO_SPACE_UNITS = 1;
   localparam int STOP_MARK_UNITS  = 1;
   localparam int FRAME_BITS       = 32;

   function automatic logic is_mark(state_t s);
      return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
   endfunction

endpackage

// File: rtl/ir_nec_transmit_carrier_gen.sv
// Free-running IR carrier with a synchronous phase restart.
// Output is high for the first CARRIER_HIGH cycles of each CARRIER_DIV period.
module ir_carrier_gen
   import ir_nec_pkg::*;
#(
   parameter int CARRIER_DIV  = 1316,
   parameter int CARRIER_HIGH = 439
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic enable,
   output logic carrier
);

   // Wide enough to also hold CARRIER_HIGH == CARRIER_DIV (carrier always on).
   localparam int CW = $clog2(CARRIER_DIV + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= '0;
      end else if (enable) begin
         if (cnt == CW'(CARRIER_DIV - 1)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign carrier = (cnt < CW'(CARRIER_HIGH));

endmodule

// File: rtl/ir_nec_transmit.sv
// NEC infrared transmitter: serialises a 32-bit code word (LSB first) or a
// repeat frame as pulse-distance marks, with optional 38 kHz modulation.
//
//   state      | meaning
//   IDLE       | tx_ready=1, waiting for tx_start / tx_repeat
//   LEAD_MARK  | 16-unit leader mark
//   LEAD_SPACE | 8-unit space before the data bits
//   REP_SPACE  | 4-unit space of a repeat frame
//   BIT_MARK   | 1-unit mark opening each bit
//   BIT_SPACE  | 3 units (bit=1) or 1 unit (bit=0) of space
//   STOP_MARK  | 1-unit closing mark
//   GAP        | GAP_UNITS of enforced idle, tx_done on the last cycle
module ir_nec_transmit
   import ir_nec_pkg::*;
#(
   parameter int UNIT_CYCLES  = 28125,
   parameter int CARRIER_DIV  = 1316,
   parameter int CARRIER_HIGH = 439,
   parameter int GAP_UNITS    = 72,
   parameter int CARRIER_EN   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tx_start,
   input  logic        tx_repeat,
   input  logic [31:0] tx_data,
   output logic        tx_ready,
   output logic        tx_done,
   output logic        tx_envelope,
   output logic        irda_txd
);

   localparam int CYC_W    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int UNIT_MAX = (GAP_UNITS > LEAD_MARK_UNITS) ? GAP_UNITS : LEAD_MARK_UNITS;
   localparam int UNIT_W   = $clog2(UNIT_MAX);
   localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(UNIT_CYCLES - 1);

   state_t            state;
   state_t            state_nxt;
   logic [CYC_W-1:0]  cyc_cnt;
   logic [UNIT_W-1:0] unit_cnt;
   logic [31:0]       shreg;
   logic [4:0]        bit_idx;
   logic              is_rep;
   logic              accept;
   logic              seg_end;
   logic              load;
   logic              restart;
   logic              carrier;
   int                seg_units;

   assign accept  = (state == IDLE) && (tx_start || tx_repeat);
   assign seg_end = (state != IDLE) && (cyc_cnt == '0) && (unit_cnt == '0);
   assign load    = accept || (seg_end && (state != GAP));

   always_comb begin
      state_nxt = state;
      seg_units = 1;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = LEAD_MARK;
               seg_units = LEAD_MARK_UNITS;
            end
         end
         LEAD_MARK: begin
            if (seg_end) begin
               state_nxt = is_rep ? REP_SPACE : LEAD_SPACE;
               seg_units = is_rep ? REP_SPACE_UNITS : LEAD_SPACE_UNITS;
            end
         end
         LEAD_SPACE: begin
            if (seg_end) begin
               state_nxt = BIT_MARK;
               seg_units = BIT_MARK_UNITS;
            end
         end
         REP_SPACE: begin
            if (seg_end) begin
               state_nxt = STOP_MARK;
               seg_units = STOP_MARK_UNITS;
            end
         end
         BIT_MARK: begin
            if (seg_end) begin
               state_nxt = BIT_SPACE;
               seg_units = shreg[0] ? ONE_SPACE_UNITS : ZERO_SPACE_UNITS;
            end
         end
         BIT_SPACE: begin
            if (seg_end) begin
               if (bit_idx == 5'(FRAME_BITS - 1)) begin
                  state_nxt = STOP_MARK;
                  seg_units = STOP_MARK_UNITS;
               end else begin
                  state_nxt = BIT_MARK;
                  seg_units = BIT_MARK_UNITS;
               end
            end
         end
         STOP_MARK: begin
            if (seg_end) begin
               state_nxt = GAP;
               seg_units = GAP_UNITS;
            end
         end
         GAP: begin
            if (seg_end) begin
               state_nxt = IDLE;
            end
         end
      endcase
   end

   // Down-counters: cyc_cnt walks one unit, unit_cnt walks the segment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cyc_cnt  <= '0;
         unit_cnt <= '0;
         shreg    <= '0;
         bit_idx  <= '0;
         is_rep   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            cyc_cnt  <= CYC_LOAD;
            unit_cnt <= UNIT_W'(seg_units - 1);
         end else if (seg_end) begin
            cyc_cnt  <= '0;
            unit_cnt <= '0;
         end else if (state != IDLE) begin
            if (cyc_cnt == '0) begin
               cyc_cnt  <= CYC_LOAD;
               unit_cnt <= unit_cnt - 1'b1;
            end else begin
               cyc_cnt <= cyc_cnt - 1'b1;
            end
         end
         if (accept) begin
            shreg   <= tx_data;
            is_rep  <= !tx_start;
            bit_idx <= '0;
         end else if ((state == BIT_SPACE) && seg_end) begin
            shreg   <= {1'b0, shreg[31:1]};
            bit_idx <= bit_idx + 1'b1;
         end
      end
   end

   // Restart the carrier phase on entry to every mark so each mark starts high.
   assign restart = load && is_mark(state_nxt);

   ir_carrier_gen #(
      .CARRIER_DIV  (CARRIER_DIV),
      .CARRIER_HIGH (CARRIER_HIGH)
   ) u_carrier (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .enable  (tx_envelope),
      .carrier (carrier)
   );

   assign tx_ready    = (state == IDLE);
   assign tx_done     = (state == GAP) && seg_end;
   assign tx_envelope = is_mark(state);
   assign irda_txd    = (CARRIER_EN != 0) ? (tx_envelope & carrier) : tx_envelope;

endmodule
